// File: rtl/rpmb_pkg.sv
// Shared types and constants for the rpmb_host bridge responder.
package rpmb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RREQ,
        RWAIT,
        DONE,
        DRAIN
    } state_e;

    localparam logic RW_WRITE   = 1'b1;
    localparam logic RW_READ    = 1'b0;
    localparam logic PHASE_ADDR = 1'b0;
    localparam logic PHASE_DATA = 1'b1;

endpackage

// File: rtl/rpmb_host_if.sv
// Backend request/response port: host side is master, memory/IO model or FIFO is slave.
interface rpmb_host_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;

    modport master (
        output req_valid, req_write, req_io, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_io, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rpmb_host_timer.sv
// Loadable down-counter; tc is high once the count has run down to zero.
module rpmb_host_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tc
);
    localparam int unsigned W = $clog2(TIMEOUT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(TIMEOUT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);
endmodule

// File: rtl/rpmb_host.sv
// Far-end responder for the MSX cartridge bridge bus: one bridge cycle in,
// one backend request (plus read response) out.
module rpmb_host
    import rpmb_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [7:0]  READ_DEFAULT = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        rw,
    input  logic [15:0] md_in,
    output logic [7:0]  md_out,
    output logic        md_oe,
    output logic        a0,
    rpmb_host_if.master bus,
    output logic        err_timeout,
    output logic [15:0] xact_count
);
    // Bridge pins and the response port go through one register stage;
    // req_ready is used directly so a handshake is seen exactly once.
    logic        cs_q, rw_q, rsp_valid_q;
    logic [15:0] md_q;
    logic [7:0]  rsp_rdata_q;

    state_e      state_q, state_d;
    logic        a0_q, a0_d, md_oe_q, md_oe_d, rw_lat_q, rw_lat_d;
    logic [7:0]  md_out_q, md_out_d, req_wdata_q, req_wdata_d;
    logic        req_valid_q, req_valid_d, req_write_q, req_write_d;
    logic [15:0] req_addr_q, req_addr_d, xact_q, xact_d;
    logic        err_q, err_d;
    logic        tmr_load, tmr_tc;

    rpmb_host_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        a0_d        = a0_q;
        md_oe_d     = md_oe_q;
        md_out_d    = md_out_q;
        rw_lat_d    = rw_lat_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        err_d       = err_q;
        xact_d      = xact_q;
        tmr_load    = 1'b0;
        unique case (state_q)
            IDLE: if (!cs_q) begin
                req_addr_d = md_q;
                rw_lat_d   = rw_q;
                a0_d       = PHASE_DATA;
                state_d    = ADDR;
            end
            ADDR: if (cs_q) begin
                a0_d    = PHASE_ADDR;
                state_d = IDLE;
            end else if (rw_lat_q == RW_WRITE) begin
                state_d = WDATA;
            end else begin
                req_valid_d = 1'b1;
                req_write_d = RW_READ;
                state_d     = RREQ;
            end
            // md_q only holds the write byte one cycle after ADDR, so the
            // request is raised on the second WDATA cycle.
            WDATA: if (cs_q) begin
                a0_d        = PHASE_ADDR;
                req_valid_d = 1'b0;
                state_d     = IDLE;
            end else if (!req_valid_q) begin
                req_wdata_d = md_q[7:0];
                req_write_d = RW_WRITE;
                req_valid_d = 1'b1;
            end else if (bus.req_ready) begin
                req_valid_d = 1'b0;
                state_d     = DONE;
            end
            RREQ: if (cs_q) begin
                a0_d        = PHASE_ADDR;
                req_valid_d = 1'b0;
                state_d     = IDLE;
            end else if (bus.req_ready) begin
                req_valid_d = 1'b0;
                tmr_load    = 1'b1;
                state_d     = RWAIT;
            end
            RWAIT: if (cs_q) begin
                a0_d = PHASE_ADDR;
                if (rsp_valid_q) begin
                    state_d = IDLE;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = DRAIN;
                end
            end else if (rsp_valid_q) begin
                md_out_d = rsp_rdata_q;
                md_oe_d  = 1'b1;
                state_d  = DONE;
            end else if (tmr_tc) begin
                md_out_d = READ_DEFAULT;
                md_oe_d  = 1'b1;
                err_d    = 1'b1;
                state_d  = DONE;
            end
            DONE: if (cs_q) begin
                a0_d    = PHASE_ADDR;
                md_oe_d = 1'b0;
                xact_d  = xact_q + 16'd1;
                state_d = IDLE;
            end
            DRAIN: if (rsp_valid_q || tmr_tc) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q        <= 1'b1;
            rw_q        <= 1'b0;
            md_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            state_q     <= IDLE;
            a0_q        <= PHASE_ADDR;
            md_oe_q     <= 1'b0;
            md_out_q    <= '0;
            rw_lat_q    <= RW_READ;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            err_q       <= 1'b0;
            xact_q      <= '0;
        end else begin
            cs_q        <= cs;
            rw_q        <= rw;
            md_q        <= md_in;
            rsp_valid_q <= bus.rsp_valid;
            rsp_rdata_q <= bus.rsp_rdata;
            state_q     <= state_d;
            a0_q        <= a0_d;
            md_oe_q     <= md_oe_d;
            md_out_q    <= md_out_d;
            rw_lat_q    <= rw_lat_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            err_q       <= err_d;
            xact_q      <= xact_d;
        end
    end

    assign a0            = a0_q;
    assign md_oe         = md_oe_q;
    assign md_out        = md_out_q;
    assign err_timeout   = err_q;
    assign xact_count    = xact_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_write = req_write_q;
    assign bus.req_io    = 1'b0;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_wdata = req_wdata_q;
endmodule
